pipe_var: RTL and testbench
===========================

Name: pipe_var

Overview:
- Matching-delay line whose delay is programmable at run time (0..MAX_DELAY), with a valid tag, stall (enable), flush and a primed indicator.
- Used where datapath latency depends on a mode (filter length, interpolation ratio), so a fixed-depth pipe cannot track it.
- Storage is a circular buffer of MAX_DELAY entries, so cost grows with depth only through memory, not through one flop stage per cycle of delay.

Parameters:
- WIDTH, 16, data width in bits.
- MAX_DELAY, 64, largest supported delay in enabled cycles; must be 1 or more.
- DW, $clog2(MAX_DELAY+1), width of the delay port; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active low.
- en  input  1  advance enable; 0 = stall, all state held.
- flush  input  1  clears all in-flight valid tags.
- delay  input  DW  requested delay in enabled cycles.
- i_valid  input  1  valid tag for i.
- i  input  WIDTH  data in.
- o_valid  output  1  valid tag delayed by the active delay.
- o  output  WIDTH  delayed data; forced to 0 when o_valid=0.
- primed  output  1  high once the active delay's worth of enabled cycles has elapsed since the last reset, flush or delay change.
- delay_err  output  1  sticky flag: a requested delay was greater than MAX_DELAY.

Behaviour:
- State:
  - mem[MAX_DELAY] of {valid, data}; data is not reset.
  - wp write pointer, range 0..MAX_DELAY-1.
  - dq active delay.
  - fill counter, range 0..dq.
  - delay_err flag.
- Clamp: dreq = min(delay, MAX_DELAY). If delay > MAX_DELAY while en=1 or in reset, delay_err is set and stays set until the next reset.
- Reset (reset=0 at a clk edge):
  - wp=0, fill=0, all valid tags cleared, dq=dreq.
  - delay_err is set only if delay > MAX_DELAY at that edge.
  - Outputs after reset: o_valid=0, o=0, primed=(dq==0).
- Delay 0: o=i and o_valid=i_valid, combinationally; primed=1; mem and wp are not touched.
- Delay dq ≥ 1:
  - Read is combinational from rp = (wp - dq) mod MAX_DELAY.
  - o_valid = mem[rp].valid and o = o_valid ? mem[rp].data : 0.
  - On a clk edge with en=1: mem[wp] <= {i_valid, i}, wp <= wp+1, wrapping from MAX_DELAY-1 to 0.
  - Result: an input accepted on enabled cycle n appears on enabled cycle n+dq.
  - Latency is counted in enabled cycles only.
- Stall (en=0): i, i_valid, flush and delay are ignored; wp, mem, dq, fill are held; o and o_valid are stable.
- Delay change: if en=1 and dreq != dq:
  - dq <= dreq, fill <= 0, and all valid tags are cleared (implicit flush).
  - The sample presented in that cycle is written with valid=0.
  - Consequence: o_valid stays 0 for dreq enabled cycles, never showing samples with mixed latency.
- Flush (flush=1, en=1): all valid tags cleared, current sample written with valid=0, fill <= 0, wp still advances. If flush coincides with a delay change, the two combine with no extra effect.
- fill: increments on each enabled cycle while fill < dq. primed = (fill == dq).
- Wrap-around: dq = MAX_DELAY must work; in that case rp == wp, and the read returns the old entry before the write.
- Simultaneous reset and en: reset wins.

Test Plan:
- dq=3, en=1, stream i=1,2,3,... with i_valid=1 → o=0 and o_valid=0 for 3 cycles, then o=1,2,3,... in successive cycles; primed rises on cycle 3.
- dq=5, hold en=0 for 4 cycles mid-stream → o and o_valid frozen during the stall; sequence resumes with no gaps or duplicates; latency is still 5 enabled cycles.
- dq=MAX_DELAY=64, stream 200 samples → o equals i delayed by 64; the pointer wraps 3 times with no corruption.
- dq=4 with data in flight, change delay to 2 → o_valid=0 for exactly 2 enabled cycles, then the new data appears with latency 2; primed drops and re-rises after 2 cycles.
- delay=70 (above MAX_DELAY=64) → dq=64, delay_err=1 and stays 1 after delay returns to 10; reset clears it.
- flush pulse with 3 valid samples in flight at dq=6 → no o_valid for the flushed samples; samples entering after the flush emerge 6 cycles later; delay=0 case gives o=i in the same cycle.

Source files
------------

// File: rtl/pipe_var.sv
// pipe_var: matching-delay line, run-time delay 0..MAX_DELAY enabled cycles, circular-buffer storage.
// Latency: dq enabled cycles (dq = clamped active delay); dq=0 is a combinational bypass.
// Backpressure: en=0 stalls everything (inputs ignored, outputs stable); no ready signalling.
module pipe_var #(
  parameter int WIDTH     = 16,
  parameter int MAX_DELAY = 64,
  parameter int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [DW-1:0]    delay,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i,
  output logic             o_valid,
  output logic [WIDTH-1:0] o,
  output logic             primed,
  output logic             delay_err
);

  // Pointer width; a one-entry buffer still needs a 1-bit pointer.
  localparam int PW   = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int LAST = MAX_DELAY - 1;
  localparam logic [DW:0]   MAX_X   = MAX_DELAY[DW:0];
  localparam logic [PW-1:0] WP_LAST = LAST[PW-1:0];

  // Data is never reset; only the valid tags need clearing.
  logic [WIDTH-1:0]     r_mem_dat [MAX_DELAY];
  logic [MAX_DELAY-1:0] r_mem_vld;
  logic [PW-1:0]        r_wp;
  logic [DW-1:0]        r_dq;
  logic [DW-1:0]        r_fill;
  logic                 r_err;

  logic             w_over;
  logic [DW-1:0]    w_dreq;
  logic             w_chg;
  logic             w_clr;
  logic [DW:0]      w_wp_x;
  logic [DW:0]      w_rp_sum;
  logic [DW:0]      w_rp_x;
  logic             w_rd_vld;
  logic [WIDTH-1:0] w_rd_dat;

  assign w_over = ({1'b0, delay} > MAX_X);
  assign w_dreq = w_over ? MAX_X[DW-1:0] : delay;
  assign w_chg  = (w_dreq != r_dq);
  // A delay change behaves as a flush so mixed-latency samples never emerge.
  assign w_clr  = flush | w_chg;

  // Read pointer (wp - dq) mod MAX_DELAY, done with one conditional subtract.
  assign w_wp_x   = (DW+1)'(r_wp);
  assign w_rp_sum = w_wp_x + MAX_X - {1'b0, r_dq};
  assign w_rp_x   = (w_rp_sum >= MAX_X) ? (w_rp_sum - MAX_X) : w_rp_sum;

  // Read mux: select the entry at the read pointer (old entry when rp == wp).
  always_comb begin
    w_rd_vld = 1'b0;
    w_rd_dat = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (w_rp_x == (DW+1)'(k)) begin
        w_rd_vld = r_mem_vld[k];
        w_rd_dat = r_mem_dat[k];
      end
    end
  end

  // Output select: bypass at delay 0, buffer read otherwise; data zeroed when not valid.
  always_comb begin
    o_valid = 1'b0;
    o       = '0;
    if (r_dq == '0) begin
      o_valid = i_valid;
      o       = i_valid ? i : '0;
    end else begin
      o_valid = w_rd_vld;
      o       = w_rd_vld ? w_rd_dat : '0;
    end
  end

  assign primed    = (r_fill == r_dq);
  assign delay_err = r_err;

  // Data storage: written only on enabled cycles with a non-zero active delay.
  always_ff @(posedge clk) begin
    if (reset && en && (r_dq != '0)) begin
      r_mem_dat[r_wp] <= i;
    end
  end

  // Control state: pointer, active delay, fill count, valid tags, sticky error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp      <= '0;
      r_fill    <= '0;
      r_mem_vld <= '0;
      r_dq      <= w_dreq;
      r_err     <= w_over;
    end else if (en) begin
      if (w_over) begin
        r_err <= 1'b1;
      end
      if (w_clr) begin
        r_fill    <= '0;
        r_mem_vld <= '0;
      end else if (r_fill < r_dq) begin
        r_fill <= r_fill + DW'(1);
      end
      // The tag write follows the clear so the current slot gets its own tag.
      if (r_dq != '0) begin
        r_mem_vld[r_wp] <= i_valid & ~w_clr;
        r_wp            <= (r_wp == WP_LAST) ? '0 : r_wp + PW'(1);
      end
      r_dq <= w_dreq;
    end
  end

endmodule

// File: tb/tb_pipe_var.sv
// tb_pipe_var: randomized stimulus against a sample-history reference model of pipe_var.
// The model indexes every enabled-cycle sample and tracks the most recent clear point.
// Outputs are compared 1 time unit after inputs change, well away from the clock edge.
module tb_pipe_var;
  localparam int WIDTH = 16;
  localparam int MAXD  = 64;
  localparam int DW    = $clog2(MAXD + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             flush;
  logic [DW-1:0]    dly;
  logic             iv;
  logic [WIDTH-1:0] id;
  logic             ov;
  logic [WIDTH-1:0] od;
  logic             primed;
  logic             derr;

  always #5 clk = ~clk;

  pipe_var #(.WIDTH(WIDTH), .MAX_DELAY(MAXD)) dut (
    .clk(clk), .reset(rst_n), .en(en), .flush(flush), .delay(dly),
    .i_valid(iv), .i(id), .o_valid(ov), .o(od), .primed(primed), .delay_err(derr)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: n = enabled edges since reset, ep = first sample index after last clear.
  int               n;
  int               ep;
  int               mdq;
  bit               merr;
  bit               hv[$];
  logic [WIDTH-1:0] hd[$];

  function automatic logic [WIDTH+2:0] exp_vec();
    logic             ev;
    logic [WIDTH-1:0] ed;
    logic             pr;
    int               j;
    if (mdq == 0) begin
      ev = iv;
      ed = iv ? id : '0;
      pr = 1'b1;
    end else begin
      j  = n - mdq;
      ev = (j >= ep) && hv[j];
      ed = ev ? hd[j] : '0;
      pr = ((n - ep) >= mdq);
    end
    return {merr, pr, ev, ed};
  endfunction

  task automatic tick();
    int  dreq;
    bit  clr;
    @(posedge clk);
    dreq = (int'(dly) > MAXD) ? MAXD : int'(dly);
    if (!rst_n) begin
      n = 0; ep = 0; mdq = dreq; merr = (int'(dly) > MAXD);
      hv.delete(); hd.delete();
    end else if (en) begin
      if (int'(dly) > MAXD) merr = 1'b1;
      clr = flush || (dreq != mdq);
      hv.push_back(iv && !clr);
      hd.push_back(id);
      n++;
      if (clr) ep = n;
      mdq = dreq;
    end
    #1;
  endtask

  task automatic set(input logic e, input logic f, input int d, input logic v, input logic [WIDTH-1:0] x);
    en = e; flush = f; dly = DW'(d); iv = v; id = x;
  endtask

  task automatic do_reset(input int d);
    rst_n = 1'b0;
    set(1'b1, 1'b0, d, 1'b0, '0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(3);
    set(1'b0, 1'b0, 3, 1'b1, 16'h55aa);
    #1;
    checks++;
    if ({derr, primed, ov, od} !== {1'b0, 1'b0, 1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", {derr, primed, ov, od}, {1'b0, 1'b0, 1'b0, 16'h0000});
    end
    do_reset(0);
    set(1'b1, 1'b0, 0, 1'b0, 16'h1234);
    #1;
    checks++;
    if ({primed, ov, od} !== {1'b1, 1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_primed_d0 got=%h exp=%h", {primed, ov, od}, {1'b1, 1'b0, 16'h0000});
    end
  endtask

  task automatic test_stream3();
    do_reset(3);
    for (int k = 0; k < 12; k++) begin
      set(1'b1, 1'b0, 3, 1'b1, WIDTH'(k + 1));
      #1;
      checks++;
      if ({derr, primed, ov, od} !== exp_vec()) begin
        failures++;
        $display("FAIL stream3 cyc=%0d got=%h exp=%h", k, {derr, primed, ov, od}, exp_vec());
      end
      if (k == 2 || k == 3) begin
        checks++;
        if ({primed, ov, od} !== ((k == 3) ? {1'b1, 1'b1, 16'd1} : {1'b0, 1'b0, 16'd0})) begin
          failures++;
          $display("FAIL stream3_edge cyc=%0d got=%h", k, {primed, ov, od});
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int cnt = 1;
    do_reset(5);
    for (int k = 0; k < 22; k++) begin
      if (k >= 7 && k < 11)
        set(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 70)), 1'($urandom_range(0, 1)), WIDTH'($urandom));
      else begin
        set(1'b1, 1'b0, 5, 1'b1, WIDTH'(cnt));
        cnt++;
      end
      #1;
      checks++;
      if ({derr, primed, ov, od} !== exp_vec()) begin
        failures++;
        $display("FAIL stall cyc=%0d got=%h exp=%h", k, {derr, primed, ov, od}, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset(MAXD);
    for (int k = 0; k < 200; k++) begin
      set(1'b1, 1'b0, MAXD, 1'($urandom_range(0, 9) != 0), WIDTH'($urandom));
      #1;
      checks++;
      if ({derr, primed, ov, od} !== exp_vec()) begin
        failures++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", k, {derr, primed, ov, od}, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_delay_change();
    do_reset(4);
    for (int k = 0; k < 20; k++) begin
      set(1'b1, 1'b0, (k < 8) ? 4 : 2, 1'b1, WIDTH'(100 + k));
      #1;
      checks++;
      if ({derr, primed, ov, od} !== exp_vec()) begin
        failures++;
        $display("FAIL delay_change cyc=%0d got=%h exp=%h", k, {derr, primed, ov, od}, exp_vec());
      end
      if (k == 9 || k == 10) begin
        checks++;
        if ({primed, ov} !== 2'b00) begin
          failures++;
          $display("FAIL delay_change_gap cyc=%0d got=%b exp=00", k, {primed, ov});
        end
      end
      tick();
    end
  endtask

  task automatic test_err();
    do_reset(10);
    for (int k = 0; k < 12; k++) begin
      set(1'b1, 1'b0, (k >= 2 && k < 5) ? 70 : 10, 1'b1, WIDTH'($urandom));
      #1;
      checks++;
      if ({derr, primed, ov, od} !== exp_vec()) begin
        failures++;
        $display("FAIL err cyc=%0d got=%h exp=%h", k, {derr, primed, ov, od}, exp_vec());
      end
      tick();
    end
    checks++;
    if (derr !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=1", derr);
    end
    do_reset(10);
    #1;
    checks++;
    if (derr !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got=%b exp=0", derr);
    end
    do_reset(70);
    #1;
    checks++;
    if (derr !== 1'b1) begin
      failures++;
      $display("FAIL err_in_reset got=%b exp=1", derr);
    end
  endtask

  task automatic test_flush();
    do_reset(6);
    for (int k = 0; k < 18; k++) begin
      set(1'b1, (k == 3), 6, 1'b1, WIDTH'(200 + k));
      #1;
      checks++;
      if ({derr, primed, ov, od} !== exp_vec()) begin
        failures++;
        $display("FAIL flush cyc=%0d got=%h exp=%h", k, {derr, primed, ov, od}, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_delay0();
    logic [WIDTH-1:0] x;
    logic             v;
    do_reset(0);
    for (int k = 0; k < 10; k++) begin
      x = WIDTH'($urandom);
      v = 1'($urandom_range(0, 3) != 0);
      set(1'b1, 1'b0, 0, v, x);
      #1;
      checks++;
      if ({primed, ov, od} !== {1'b1, v, (v ? x : 16'h0000)}) begin
        failures++;
        $display("FAIL delay0 cyc=%0d got=%h exp=%h", k, {primed, ov, od}, {1'b1, v, (v ? x : 16'h0000)});
      end
      tick();
    end
  endtask

  task automatic test_random();
    int d = 7;
    do_reset(d);
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 31) == 0) d = int'($urandom_range(0, 70));
      if ($urandom_range(0, 199) == 0) begin
        do_reset(d);
      end
      set(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), d,
          1'($urandom_range(0, 4) != 0), WIDTH'($urandom));
      #1;
      checks++;
      if ({derr, primed, ov, od} !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d dq=%0d got=%h exp=%h", k, mdq, {derr, primed, ov, od}, exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set(1'b0, 1'b0, 0, 1'b0, '0);
    n = 0; ep = 0; mdq = 0; merr = 1'b0;
    #2;
    test_reset();
    test_stream3();
    test_stall();
    test_wrap();
    test_delay_change();
    test_err();
    test_flush();
    test_delay0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
